// File: rtl/latency_stats_pkg.sv
// Shared encodings and helpers for the latency statistics block.
package latency_stats_pkg;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_SEND
    } tx_state_e;

    localparam int unsigned REPORT_WORDS = 4;
    localparam int unsigned IDX_WIDTH    = 2;

    localparam int unsigned W_SAMP_AVG = 0;
    localparam int unsigned W_PKT_AVG  = 1;
    localparam int unsigned W_PKT_MIN  = 2;
    localparam int unsigned W_PKT_MAX  = 3;

    // Clamp val to width bits: anything that does not fit becomes all-ones.
    function automatic logic [127:0] saturate(input logic [127:0] val, input int unsigned width);
        logic [127:0] mask;
        mask = (width >= 128) ? '1 : ((128'd1 << width) - 128'd1);
        return ((val & ~mask) != '0) ? mask : val;
    endfunction

endpackage

// File: rtl/latency_report_tx.sv
// Report snapshot bank and sender FSM: loads four words when idle and streams them out.
module latency_report_tx
    import latency_stats_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    load_i,
    input  logic [REPORT_WORDS-1:0][DATA_WIDTH-1:0] words_i,
    input  logic                                    tready_i,
    output logic                                    busy_o,
    output logic                                    tvalid_o,
    output logic                                    tlast_o,
    output logic [DATA_WIDTH-1:0]                   tdata_o
);

    tx_state_e                               state_q, state_d;
    logic [IDX_WIDTH-1:0]                    idx_q, idx_d;
    logic [REPORT_WORDS-1:0][DATA_WIDTH-1:0] words_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (load_i && (state_q == ST_IDLE)) begin
                words_q <= words_i;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tvalid_o = 1'b0;
        tlast_o  = 1'b0;
        tdata_o  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (load_i) begin
                    state_d = ST_SEND;
                    idx_d   = '0;
                end
            end
            ST_SEND: begin
                tvalid_o = 1'b1;
                tdata_o  = words_q[idx_q];
                tlast_o  = (idx_q == IDX_WIDTH'(REPORT_WORDS - 1));
                if (tready_i) begin
                    if (tlast_o) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign busy_o = (state_q != ST_IDLE);

endmodule

// File: rtl/latency_stats_report.sv
// Windowed packet/sample latency statistics with a 4-word report stream and drop counter.
module latency_stats_report
    import latency_stats_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned TS_WIDTH        = 64,
    parameter int unsigned ACC_WIDTH       = 64,
    parameter int unsigned MAX_WINDOW_LOG2 = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_tx_seqnum,
    input  logic [DATA_WIDTH-1:0] m_axis_data_tdata,
    input  logic                  m_axis_data_tlast,
    input  logic                  m_axis_data_tvalid,
    output logic                  m_axis_data_tready,
    input  logic [127:0]          m_axis_data_tuser,
    output logic [DATA_WIDTH-1:0] s_axis_data_tdata,
    output logic                  s_axis_data_tlast,
    output logic                  s_axis_data_tvalid,
    input  logic                  s_axis_data_tready,
    output logic [127:0]          s_axis_data_tuser,
    input  logic [TS_WIDTH-1:0]   timer,
    input  logic [63:0]           header,
    input  logic [4:0]            window_log2,
    input  logic [4:0]            spp_log2,
    output logic [15:0]           drop_count
);

    localparam int unsigned CNT_WIDTH = 17;

    logic                 cfg_valid_q, cfg_valid_d;
    logic [4:0]           win_q, win_d, spp_q, spp_d;
    logic [4:0]           win_live, win_eff, spp_eff;
    logic [ACC_WIDTH-1:0] acc_samp_q, acc_samp_d, acc_pkt_q, acc_pkt_d;
    logic [63:0]          min_q, min_d, max_q, max_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [15:0]          drop_q, drop_d;

    logic                 beat, pkt_end, close, tx_busy, tx_load;
    logic [31:0]          samp_lat;
    logic [63:0]          plat;
    logic [ACC_WIDTH-1:0] acc_samp_nx, acc_pkt_nx;
    logic [63:0]          min_nx, max_nx;
    logic [CNT_WIDTH-1:0] cnt_nx;
    logic [5:0]           samp_shamt;
    logic                 unused_tuser;

    logic [REPORT_WORDS-1:0][DATA_WIDTH-1:0] report_words;

    assign unused_tuser = ^m_axis_data_tuser[127:64];

    assign m_axis_data_tready = ~reset;
    assign s_axis_data_tuser  = {header, 64'(timer)};
    assign drop_count         = drop_q;

    assign win_live = (32'(window_log2) > MAX_WINDOW_LOG2) ? 5'(MAX_WINDOW_LOG2) : window_log2;

    // Until the first edge after reset the live inputs stand in for the latched config.
    assign win_eff = cfg_valid_q ? win_q : win_live;
    assign spp_eff = cfg_valid_q ? spp_q : spp_log2;

    assign beat     = m_axis_data_tvalid & m_axis_data_tready;
    assign pkt_end  = beat & m_axis_data_tlast;
    assign samp_lat = timer[31:0] - 32'(m_axis_data_tdata);
    assign plat     = 64'(timer) - m_axis_data_tuser[63:0];

    assign acc_samp_nx = acc_samp_q + ACC_WIDTH'(samp_lat);
    assign acc_pkt_nx  = acc_pkt_q + ACC_WIDTH'(plat);
    assign min_nx      = (plat < min_q) ? plat : min_q;
    assign max_nx      = (plat > max_q) ? plat : max_q;
    assign cnt_nx      = cnt_q + 1'b1;

    assign close   = pkt_end && (cnt_nx == (CNT_WIDTH'(1) << win_eff));
    assign tx_load = close & ~clear_tx_seqnum & ~tx_busy;

    // Report words are built from the closing beat's updated values.
    assign samp_shamt = 6'(win_eff) + 6'(spp_eff);
    assign report_words[W_SAMP_AVG] =
        DATA_WIDTH'(saturate(128'(acc_samp_nx >> samp_shamt), DATA_WIDTH));
    assign report_words[W_PKT_AVG] =
        DATA_WIDTH'(saturate(128'(acc_pkt_nx >> win_eff), DATA_WIDTH));
    assign report_words[W_PKT_MIN] = DATA_WIDTH'(saturate(128'(min_nx), DATA_WIDTH));
    assign report_words[W_PKT_MAX] = DATA_WIDTH'(saturate(128'(max_nx), DATA_WIDTH));

    always_comb begin
        cfg_valid_d = 1'b1;
        win_d       = win_q;
        spp_d       = spp_q;
        acc_samp_d  = acc_samp_q;
        acc_pkt_d   = acc_pkt_q;
        min_d       = min_q;
        max_d       = max_q;
        cnt_d       = cnt_q;
        drop_d      = drop_q;

        if (!cfg_valid_q) begin
            win_d = win_live;
            spp_d = spp_log2;
        end

        if (clear_tx_seqnum || close) begin
            acc_samp_d = '0;
            acc_pkt_d  = '0;
            min_d      = '1;
            max_d      = '0;
            cnt_d      = '0;
            win_d      = win_live;
            spp_d      = spp_log2;
        end else if (beat) begin
            acc_samp_d = acc_samp_nx;
            if (pkt_end) begin
                acc_pkt_d = acc_pkt_nx;
                min_d     = min_nx;
                max_d     = max_nx;
                cnt_d     = cnt_nx;
            end
        end

        if (close && !clear_tx_seqnum && tx_busy && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_valid_q <= 1'b0;
            win_q       <= '0;
            spp_q       <= '0;
            acc_samp_q  <= '0;
            acc_pkt_q   <= '0;
            min_q       <= '1;
            max_q       <= '0;
            cnt_q       <= '0;
            drop_q      <= '0;
        end else begin
            cfg_valid_q <= cfg_valid_d;
            win_q       <= win_d;
            spp_q       <= spp_d;
            acc_samp_q  <= acc_samp_d;
            acc_pkt_q   <= acc_pkt_d;
            min_q       <= min_d;
            max_q       <= max_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
        end
    end

    latency_report_tx #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_tx (
        .clk     (clk),
        .reset   (reset),
        .load_i  (tx_load),
        .words_i (report_words),
        .tready_i(s_axis_data_tready),
        .busy_o  (tx_busy),
        .tvalid_o(s_axis_data_tvalid),
        .tlast_o (s_axis_data_tlast),
        .tdata_o (s_axis_data_tdata)
    );

endmodule

// File: tb/tb_latency_stats_report.sv
// Directed scoreboard bench for latency_stats_report.
module tb_latency_stats_report;

    logic         clk = 1'b0;
    logic         reset;
    logic         clear;
    logic [31:0]  m_tdata;
    logic         m_tlast, m_tvalid, m_tready;
    logic [127:0] m_tuser;
    logic [31:0]  s_tdata;
    logic         s_tlast, s_tvalid, s_tready;
    logic [127:0] s_tuser;
    logic [63:0]  timer;
    logic [63:0]  header;
    logic [4:0]   window_log2, spp_log2;
    logic [15:0]  drop_count;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [63:0] tcur = 64'd1000;

    always #5 clk = ~clk;

    latency_stats_report dut (
        .clk               (clk),
        .reset             (reset),
        .clear_tx_seqnum   (clear),
        .m_axis_data_tdata (m_tdata),
        .m_axis_data_tlast (m_tlast),
        .m_axis_data_tvalid(m_tvalid),
        .m_axis_data_tready(m_tready),
        .m_axis_data_tuser (m_tuser),
        .s_axis_data_tdata (s_tdata),
        .s_axis_data_tlast (s_tlast),
        .s_axis_data_tvalid(s_tvalid),
        .s_axis_data_tready(s_tready),
        .s_axis_data_tuser (s_tuser),
        .timer             (timer),
        .header            (header),
        .window_log2       (window_log2),
        .spp_log2          (spp_log2),
        .drop_count        (drop_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat32(input logic [63:0] v);
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    task automatic push_word(input logic [31:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    // Reference report for a window: sums, extremes and the window's latched config.
    task automatic push_window(input logic [63:0] samp_sum, input logic [63:0] pkt_sum,
                               input logic [63:0] mn, input logic [63:0] mx,
                               input int win, input int spp);
        push_word(sat32(samp_sum >> (win + spp)), 1'b0);
        push_word(sat32(pkt_sum >> win), 1'b0);
        push_word(sat32(mn), 1'b0);
        push_word(sat32(mx), 1'b1);
    endtask

    // One clock: outputs are checked at the negedge, inputs commit at the posedge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (s_tvalid && s_tready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL sb_unexpected observed=%0h expected=no_beat", s_tdata);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rpt_data", 64'(s_tdata), 64'(e.data));
                chk("rpt_last", 64'(s_tlast), 64'(e.last));
            end
        end
        @(posedge clk);
        #1;
        tcur = tcur + 64'd1;
    endtask

    task automatic beat_t(input logic last, input logic [63:0] tm, input logic [31:0] samp,
                          input logic [63:0] plat);
        timer    = tm;
        m_tdata  = tm[31:0] - samp;
        m_tuser  = {64'h0, tm - plat};
        m_tlast  = last;
        m_tvalid = 1'b1;
        tick();
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
    endtask

    task automatic pkt(input int nbeats, input logic [31:0] samp, input logic [63:0] plat);
        for (int i = 0; i < nbeats; i++) begin
            beat_t(i == nbeats - 1, tcur, samp, plat);
        end
    endtask

    task automatic drain(input int n);
        s_tready = 1'b1;
        repeat (n) tick();
    endtask

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        m_tdata = '0;
        m_tlast = 1'b0;
        m_tvalid = 1'b0;
        m_tuser = '0;
        s_tready = 1'b1;
        timer = tcur;
        header = 64'hABCD_0000_1234_5678;
        window_log2 = 5'd2;
        spp_log2 = 5'd2;

        repeat (2) tick();
        chk("rst_m_tready", 64'(m_tready), 64'd0);
        chk("rst_tvalid", 64'(s_tvalid), 64'd0);
        chk("rst_tlast", 64'(s_tlast), 64'd0);
        chk("rst_tdata", 64'(s_tdata), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        reset = 1'b0;
        tick();
        chk("m_tready", 64'(m_tready), 64'd1);

        // Basic window: 4 packets x 4 samples.
        push_window(64'd160, 64'd1000, 64'd100, 64'd400, 2, 2);
        pkt(4, 32'd10, 64'd100);
        pkt(4, 32'd10, 64'd200);
        pkt(4, 32'd10, 64'd300);
        pkt(4, 32'd10, 64'd400);
        chk("close_lat_n1", 64'(s_tvalid), 64'd1);
        chk("tuser_hdr", s_tuser[127:64], header);
        chk("tuser_tmr", s_tuser[63:0], timer);
        drain(4);
        chk("basic_idle", 64'(s_tvalid), 64'd0);
        chk("basic_drop", 64'(drop_count), 64'd0);

        // Backpressure during W1.
        push_window(64'd320, 64'd6000, 64'd1000, 64'd2000, 2, 2);
        pkt(4, 32'd20, 64'd1000);
        pkt(4, 32'd20, 64'd1000);
        pkt(4, 32'd20, 64'd2000);
        pkt(4, 32'd20, 64'd2000);
        drain(1);
        s_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_data", 64'(s_tdata), 64'd1500);
            chk("bp_hold_last", 64'(s_tlast), 64'd0);
        end
        drain(3);
        chk("bp_drop", 64'(drop_count), 64'd0);

        // Busy drop with one-packet windows.
        window_log2 = 5'd0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        s_tready = 1'b0;
        push_window(64'd5, 64'd77, 64'd77, 64'd77, 0, 2);
        pkt(1, 32'd5, 64'd77);
        pkt(1, 32'd6, 64'd99);
        tick();
        chk("busy_drop", 64'(drop_count), 64'd1);
        chk("busy_w0", 64'(s_tdata), 64'd1);
        chk("busy_valid", 64'(s_tvalid), 64'd1);
        drain(4);
        chk("busy_drop_hold", 64'(drop_count), 64'd1);

        // Timestamp wrap, then a saturating latency.
        push_window(64'd8, 64'd10, 64'd10, 64'd10, 0, 2);
        beat_t(1'b1, 64'd5, 32'd8, 64'd10);
        drain(4);
        push_window(64'd8, 64'h100_0000_0000, 64'h100_0000_0000, 64'h100_0000_0000, 0, 2);
        pkt(1, 32'd8, 64'h100_0000_0000);
        drain(4);

        // Window size change mid-window takes effect one window later.
        window_log2 = 5'd1;
        push_window(64'd4, 64'd40, 64'd40, 64'd40, 0, 2);
        pkt(1, 32'd4, 64'd40);
        drain(4);
        pkt(1, 32'd4, 64'd60);
        tick();
        chk("mid_no_report", 64'(s_tvalid), 64'd0);
        window_log2 = 5'd0;
        push_window(64'd8, 64'd140, 64'd60, 64'd80, 1, 2);
        pkt(1, 32'd4, 64'd80);
        drain(4);

        // Clear on a closing beat wins.
        clear = 1'b1;
        pkt(1, 32'd4, 64'd55);
        clear = 1'b0;
        tick();
        chk("clr_no_report", 64'(s_tvalid), 64'd0);
        chk("clr_drop", 64'(drop_count), 64'd1);
        push_window(64'd12, 64'd33, 64'd33, 64'd33, 0, 2);
        pkt(1, 32'd12, 64'd33);
        drain(4);

        // Async reset while W2 is on the bus.
        push_word(32'd1, 1'b0);
        push_word(32'd50, 1'b0);
        pkt(1, 32'd4, 64'd50);
        drain(2);
        chk("pre_rst_w2", 64'(s_tdata), 64'd50);
        #2 reset = 1'b1;
        #1 chk("async_tvalid", 64'(s_tvalid), 64'd0);
        chk("async_m_tready", 64'(m_tready), 64'd0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("post_rst_drop", 64'(drop_count), 64'd0);
        chk("post_rst_tvalid", 64'(s_tvalid), 64'd0);
        chk("post_rst_m_tready", 64'(m_tready), 64'd1);
        push_window(64'd4, 64'd21, 64'd21, 64'd21, 0, 2);
        pkt(1, 32'd4, 64'd21);
        drain(5);

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/latency_stats_report.md
# latency_stats_report

Parametrised latency-statistics block for an RFNoC compute engine, sitting between the axi_wrapper `m_axis_data` and `s_axis_data` ports. It computes per-packet latency (`timer` minus the tuser receive timestamp) and per-sample latency (`timer[31:0]` minus the sample's tdata timestamp) over power-of-two packet windows. It tracks sum, min and max. At each window close it emits a 4-word report packet; if the previous report is still in flight, it drops the new report and counts the drop.

## Interface
Parameters:
- `DATA_WIDTH`, 32: sample/report word width.
- `TS_WIDTH`, 64: timer and tuser timestamp width.
- `ACC_WIDTH`, 64: accumulator width; accumulators wrap modulo 2^ACC_WIDTH.
- `MAX_WINDOW_LOG2`, 16: largest permitted window exponent.

Ports (clock and reset first):
- `clk` in 1: single clock for all logic.
- `reset` in 1: reset, asynchronous and active-high.
- `clear_tx_seqnum` in 1: synchronous restart of the current window.
- `m_axis_data_tdata` in DATA_WIDTH: per-sample transmit timestamp.
- `m_axis_data_tlast`, `m_axis_data_tvalid` in 1: input stream controls.
- `m_axis_data_tready` out 1: input ready.
- `m_axis_data_tuser` in 128: bits [63:0] carry the packet receive timestamp.
- `s_axis_data_tdata` out DATA_WIDTH: report words.
- `s_axis_data_tlast`, `s_axis_data_tvalid` out 1: report stream controls.
- `s_axis_data_tready` in 1: report stream backpressure.
- `s_axis_data_tuser` out 128: `{header, timer}`.
- `timer` in TS_WIDTH: free-running shared time.
- `header` in 64: CHDR header for the report packet.
- `window_log2` in 5: packets per window = 2^window_log2; values above MAX_WINDOW_LOG2 clamp to MAX_WINDOW_LOG2.
- `spp_log2` in 5: log2 samples per packet, used for the sample average.
- `drop_count` out 16: saturating count of dropped reports.

## Operation
- `m_axis_data_tready` is 0 in reset and 1 otherwise. The block is a pure sink and never backpressures.
- **Accepted beat:** each beat with tvalid=1 adds `timer[31:0] - tdata` (32-bit modulo, zero-extended) to `acc_samp`.
- **Packet end:** a beat with tlast also computes `plat = timer - tuser[63:0]` (64-bit modulo). It then:
  - adds `plat` to `acc_pkt`;
  - updates `min_pkt` and `max_pkt` (64-bit unsigned compare);
  - increments `pkt_cnt` (17 bits).
- **Config latch:** `window_log2` and `spp_log2` are latched at window start. Changes mid-window take effect at the next window.
- **Window close:** the window closes on the tlast beat where `pkt_cnt + 1 == 2^win`. That beat's contributions are included. At the same edge the block snapshots four report words:
  - W0 = `(acc_samp' >> (win + spp))`;
  - W1 = `(acc_pkt' >> win)`;
  - W2 = `min_pkt'`;
  - W3 = `max_pkt'`.
  - Each word saturates to all-ones if its value exceeds DATA_WIDTH bits.
- **New window:** the closing edge also clears the accumulators and `pkt_cnt`, sets min to all-ones and max to 0, and re-latches config.
- **Drop on busy:** if the sender is not IDLE at window close, the snapshot is discarded and `drop_count` increments, holding at 0xFFFF. Accumulation restarts regardless.
- **Clear:** `clear_tx_seqnum` clears the window state as a reset does, but does not abort a report in flight. If it coincides with a closing beat, the clear wins: no report and no drop.
- **Sender FSM** (ST_IDLE → ST_SEND → ST_IDLE):
  - ST_IDLE → ST_SEND on snapshot load, with word index 0.
  - In ST_SEND, `tvalid`=1 and `tdata`=W[idx].
  - idx advances on `tvalid && tready`.
  - `tlast`=1 when idx=3.
  - The handshake at idx=3 returns to ST_IDLE.
- `s_axis_data_tuser` tracks `{header, timer}` combinationally.

## Timing
- Reset values: `s_axis_data_tvalid`=0, `tlast`=0, `tdata`=0, `drop_count`=0, `m_axis_data_tready`=0; FSM in ST_IDLE, min=all-ones, config latched from inputs.
- Closing beat sampled at edge N gives `s_axis_data_tvalid`=1 with W0 in cycle N+1. With tready held high, W3 and tlast appear in N+4.
- While tvalid=1 and tready=0, tdata and tlast stay stable.
- Reset asserted mid-report drops tvalid asynchronously and loses the report.
- The minimum legal window (win=0, one packet) can close every cycle. Closes while the sender is busy are counted as drops.

## Structure
- Package `latency_stats_pkg` holds:
  - state encodings ST_IDLE and ST_SEND;
  - report word indices W_SAMP_AVG=0, W_PKT_AVG=1, W_PKT_MIN=2, W_PKT_MAX=3;
  - REPORT_WORDS=4;
  - the saturate function.
- Sub-module `latency_report_tx` holds the 4-word snapshot register bank and the sender FSM, with a load/busy interface.

## Test plan
- **Basic window:** win=2, spp=2, timer-tuser=100/200/300/400, sample latency 10 each. Required report: W0=10, W1=250, W2=100, W3=400, with tlast on W3.
- **Backpressure:** tready low for 5 cycles during W1. Required: W1 held stable, then W2 and W3 follow in order, with no drop.
- **Busy drop:** win=0 with two tlast beats 1 cycle apart and tready=0. Required: first report pending, drop_count=1, first report's data intact.
- **Wrap and saturate:** timer=5, tuser=2^64-5 gives plat=10. A plat of 2^40 gives W3=0xFFFFFFFF.
- **Mid-window changes:** change window_log2 mid-window. Required: the current window uses the old value and the next window the new one. `clear_tx_seqnum` on a closing beat gives no report and drop_count unchanged.
- **Async reset:** assert reset during W2. Required: tvalid=0 immediately, and all counters are 0 after release.
